// File: rtl/rv32i_pkg.sv
// Shared core definitions: debug register map and debug-port arbiter types.
package rv32i_pkg;

    localparam logic [11:0] DBG_CTRL_ADDR   = 12'h000;
    localparam logic [11:0] DBG_STATUS_ADDR = 12'h004;
    localparam logic [11:0] DBG_PC_ADDR     = 12'h008;
    localparam logic [11:0] DBG_INSTR_ADDR  = 12'h00C;
    localparam logic [11:0] DBG_BP0_ADDR    = 12'h040;
    localparam logic [11:0] DBG_GPR_BASE    = 12'h100;

    localparam int APB_ARB_TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SETUP,
        ARB_ACCESS
    } arb_state_t;

endpackage

// File: rtl/apb3_dbg_arbiter_rr_arbiter.sv
// Round-robin request picker; owns the last_grant pointer.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               grant_en,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx
);

    logic [IW-1:0] last_grant;
    logic          found;
    int            j;

    // Search starts one past the previous winner and wraps.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            j = int'(last_grant) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && req[j]) begin
                found     = 1'b1;
                grant_idx = IW'(j);
            end
        end
        if (found) grant[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= IW'(NUM_REQ - 1);
        end else if (grant_en && found) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/apb3_dbg_arbiter.sv
// N-to-1 APB3 arbiter for the core debug slave port.
// Optional access watchdog: define APB3_ARB_TIMEOUT_EN.
module apb3_dbg_arbiter
    import rv32i_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = APB_ARB_TIMEOUT_DEFAULT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]  s_paddr,
    input  logic [NUM_REQ-1:0]              s_psel,
    input  logic [NUM_REQ-1:0]              s_penable,
    input  logic [NUM_REQ-1:0]              s_pwrite,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  s_pwdata,
    output logic [NUM_REQ-1:0][DATA_W-1:0]  s_prdata,
    output logic [NUM_REQ-1:0]              s_pready,
    output logic [NUM_REQ-1:0]              s_pslverr,
    output logic [ADDR_W-1:0]               m_paddr,
    output logic                            m_psel,
    output logic                            m_penable,
    output logic                            m_pwrite,
    output logic [DATA_W-1:0]               m_pwdata,
    input  logic [DATA_W-1:0]               m_prdata,
    input  logic                            m_pready,
    input  logic                            m_pslverr,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy
);

    localparam int IW = $clog2(NUM_REQ);

    arb_state_t         state;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               write_q;
    logic [IW-1:0]      gid_q;
    logic [NUM_REQ-1:0] grant_oh;
    logic [IW-1:0]      grant_idx;
    logic               grant_en;
    logic               done;
    logic               tmo;

    assign grant_en = (state == ARB_IDLE) && (|s_psel);
    assign done     = (state == ARB_ACCESS) && (m_pready || tmo);

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (s_psel),
        .grant_en  (grant_en),
        .grant     (grant_oh),
        .grant_idx (grant_idx)
    );

    // The latched copy is cleared on completion so m_* read 0 while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            gid_q   <= '0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (grant_en) begin
                        state   <= ARB_SETUP;
                        gid_q   <= grant_idx;
                        addr_q  <= s_paddr[grant_idx];
                        wdata_q <= s_pwdata[grant_idx];
                        write_q <= s_pwrite[grant_idx];
                    end
                end
                ARB_SETUP: state <= ARB_ACCESS;
                ARB_ACCESS: begin
                    if (done) begin
                        state   <= ARB_IDLE;
                        addr_q  <= '0;
                        wdata_q <= '0;
                        write_q <= 1'b0;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifdef APB3_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;

    always_ff @(posedge clk) begin
        if (rst || state == ARB_SETUP) begin
            tcnt <= '0;
        end else if (state == ARB_ACCESS && !done) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // A real slave response in the same cycle takes precedence.
    assign tmo = (state == ARB_ACCESS) && !m_pready
               && (tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo;
    assign unused_tmo = ^32'(TIMEOUT_CYCLES);
    assign tmo = 1'b0;
`endif

    always_comb begin
        s_pready  = '0;
        s_pslverr = '0;
        s_prdata  = '0;
        if (state == ARB_ACCESS) begin
            s_pready[gid_q]  = m_pready | tmo;
            s_pslverr[gid_q] = m_pslverr | tmo;
            s_prdata[gid_q]  = tmo ? '0 : m_prdata;
        end
    end

    assign m_psel    = (state != ARB_IDLE);
    assign m_penable = (state == ARB_ACCESS);
    assign m_paddr   = addr_q;
    assign m_pwdata  = wdata_q;
    assign m_pwrite  = write_q;
    assign grant_id  = gid_q;
    assign busy      = (state != ARB_IDLE);

    logic unused_ok;
    assign unused_ok = ^{s_penable, grant_oh};

endmodule

// File: tb/tb_apb3_dbg_arbiter.sv
// Directed bench for apb3_dbg_arbiter with two masters.
// Watchdog section is active when APB3_ARB_TIMEOUT_EN is defined.
module tb_apb3_dbg_arbiter;
    import rv32i_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0][11:0] s_paddr;
    logic [1:0]       s_psel;
    logic [1:0]       s_penable;
    logic [1:0]       s_pwrite;
    logic [1:0][31:0] s_pwdata;
    logic [1:0][31:0] s_prdata;
    logic [1:0]       s_pready;
    logic [1:0]       s_pslverr;
    logic [11:0]      m_paddr;
    logic             m_psel;
    logic             m_penable;
    logic             m_pwrite;
    logic [31:0]      m_pwdata;
    logic [31:0]      m_prdata;
    logic             m_pready;
    logic             m_pslverr;
    logic             grant_id;
    logic             busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb3_dbg_arbiter #(
        .NUM_REQ(2), .ADDR_W(12), .DATA_W(32), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .s_paddr(s_paddr), .s_psel(s_psel), .s_penable(s_penable),
        .s_pwrite(s_pwrite), .s_pwdata(s_pwdata),
        .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
        .m_paddr(m_paddr), .m_psel(m_psel), .m_penable(m_penable),
        .m_pwrite(m_pwrite), .m_pwdata(m_pwdata),
        .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
        .grant_id(grant_id), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        int g;
        rst       = 1'b1;
        s_paddr   = '0;
        s_psel    = '0;
        s_penable = '0;
        s_pwrite  = '0;
        s_pwdata  = '0;
        m_prdata  = '0;
        m_pready  = 1'b0;
        m_pslverr = 1'b0;
        step();
        step();
        rst = 1'b0;
        settle();
        chk("rst_busy", busy, 0);
        chk("rst_psel", m_psel, 0);
        chk("rst_penable", m_penable, 0);
        chk("rst_paddr", m_paddr, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_pready", s_pready, 0);

        // Single write from port 0, zero-wait slave.
        s_psel[0]   = 1'b1;
        s_paddr[0]  = DBG_CTRL_ADDR;
        s_pwrite[0] = 1'b1;
        s_pwdata[0] = 32'h0000_0001;
        settle();
        chk("w_cycN_psel", m_psel, 0);
        step();
        s_penable[0] = 1'b1;
        settle();
        chk("w_setup_psel", m_psel, 1);
        chk("w_setup_pen", m_penable, 0);
        chk("w_setup_addr", m_paddr, DBG_CTRL_ADDR);
        chk("w_setup_write", m_pwrite, 1);
        chk("w_setup_pready", s_pready, 0);
        step();
        m_pready = 1'b1;
        settle();
        chk("w_acc_pen", m_penable, 1);
        chk("w_acc_wdata", m_pwdata, 32'h0000_0001);
        chk("w_acc_pready", s_pready, 2'b01);
        step();
        m_pready     = 1'b0;
        s_psel[0]    = 1'b0;
        s_penable[0] = 1'b0;
        s_pwrite[0]  = 1'b0;
        settle();
        chk("w_idle_busy", busy, 0);
        chk("w_idle_psel", m_psel, 0);
        chk("w_idle_paddr", m_paddr, 0);

        // Both ports keep reading the PC; grants must alternate from port 0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        s_paddr[0] = DBG_PC_ADDR;
        s_paddr[1] = DBG_PC_ADDR;
        s_psel     = 2'b11;
        for (int i = 0; i < 8; i++) begin
            g = i % 2;
            step();
            settle();
            chk("rr_gid", grant_id, g);
            chk("rr_setup_pready", s_pready, 0);
            s_penable[g] = 1'b1;
            step();
            m_pready = 1'b1;
            m_prdata = 32'h0000_0100 + 32'(4 * i);
            settle();
            chk("rr_pready", s_pready, (g == 0) ? 2'b01 : 2'b10);
            chk("rr_rdata", s_prdata[g], 32'h0000_0100 + 32'(4 * i));
            chk("rr_loser_rdata", s_prdata[1-g], 0);
            step();
            m_pready     = 1'b0;
            s_penable[g] = 1'b0;
            settle();
            chk("rr_idle_gap", busy, 0);
        end
        s_psel = 2'b00;

        // Port 1 write with 5 wait states ending in a slave error.
        s_psel[1]   = 1'b1;
        s_paddr[1]  = DBG_BP0_ADDR;
        s_pwrite[1] = 1'b1;
        s_pwdata[1] = 32'hDEAD_BEEF;
        step();
        s_penable[1] = 1'b1;
        settle();
        chk("ws_gid", grant_id, 1);
        step();
        s_paddr[1]  = 12'hFFF;
        s_pwdata[1] = 32'h1234_5678;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("ws_stall", s_pready, 0);
            chk("ws_addr_hold", m_paddr, DBG_BP0_ADDR);
            chk("ws_data_hold", m_pwdata, 32'hDEAD_BEEF);
            step();
        end
        m_pready  = 1'b1;
        m_pslverr = 1'b1;
        settle();
        chk("ws_pready", s_pready, 2'b10);
        chk("ws_pslverr", s_pslverr, 2'b10);
        step();
        m_pready  = 1'b0;
        m_pslverr = 1'b0;
        s_psel    = 2'b00;
        s_penable = 2'b00;
        s_pwrite  = 2'b00;

        // Reset in the middle of an access drops the transfer.
        s_psel[1] = 1'b1;
        step();
        s_penable[1] = 1'b1;
        step();
        settle();
        chk("mr_in_access", m_penable, 1);
        rst = 1'b1;
        step();
        m_pready = 1'b1;
        settle();
        chk("mr_busy", busy, 0);
        chk("mr_psel", m_psel, 0);
        chk("mr_pready", s_pready, 0);
        rst       = 1'b0;
        m_pready  = 1'b0;
        s_penable = 2'b00;
        s_psel    = 2'b11;
        step();
        settle();
        chk("mr_first_gid", grant_id, 0);
        s_penable[0] = 1'b1;
        step();
        m_pready = 1'b1;
        settle();
        chk("mr_first_pready", s_pready, 2'b01);
        step();
        m_pready  = 1'b0;
        s_psel    = 2'b00;
        s_penable = 2'b00;

        // Port 1 withdraws before it is granted: no transfer for it.
        s_psel[0] = 1'b1;
        step();
        s_psel[1]    = 1'b1;
        s_penable[0] = 1'b1;
        step();
        s_psel[1] = 1'b0;
        m_pready  = 1'b1;
        settle();
        chk("drop_pready", s_pready, 2'b01);
        step();
        m_pready  = 1'b0;
        s_psel    = 2'b00;
        s_penable = 2'b00;
        step();
        settle();
        chk("drop_busy", busy, 0);
        chk("drop_psel", m_psel, 0);

`ifdef APB3_ARB_TIMEOUT_EN
        // Slave never answers; watchdog completes with an error.
        m_prdata  = 32'hAAAA_5555;
        s_psel[0] = 1'b1;
        step();
        s_penable[0] = 1'b1;
        step();
        for (int k = 1; k < 8; k++) begin
            settle();
            chk("to_wait", s_pready, 0);
            step();
        end
        settle();
        chk("to_pready", s_pready, 2'b01);
        chk("to_pslverr", s_pslverr, 2'b01);
        chk("to_prdata", s_prdata[0], 0);
        s_psel    = 2'b10;
        s_penable = 2'b00;
        step();
        settle();
        chk("to_idle", busy, 0);
        step();
        settle();
        chk("to_next_gid", grant_id, 1);
        chk("to_next_psel", m_psel, 1);
        s_penable[1] = 1'b1;
        step();
        m_pready = 1'b1;
        settle();
        chk("to_next_pready", s_pready, 2'b10);
        step();
        m_pready  = 1'b0;
        s_psel    = 2'b00;
        s_penable = 2'b00;
`endif

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
